// File: rtl/add32_check.sv
// Result checker for the add32 adder: recomputes a+b+cin in a two-stage pipeline and keeps pass/error statistics.
// Defining ADD32_CHECK_DISPLAY_EN adds $display reporting of mismatches and of the final counts.
module add32_check #(
    parameter int IDXW = 12
) (
    input  logic            m_clock,
    input  logic            p_reset,
    input  logic            clear,
    input  logic            vld,
    input  logic            last,
    input  logic [IDXW-1:0] idx,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic            cin,
    input  logic [31:0]     sum,
    input  logic            cout,
    output logic            chk_vld,
    output logic            chk_ok,
    output logic [IDXW-1:0] pass_cnt,
    output logic [IDXW-1:0] err_cnt,
    output logic [IDXW-1:0] first_err_idx,
    output logic            first_err_seen,
    output logic            done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IDXW-1:0] CNT_MAX = '1;

    state_t          state;
    logic            accept;
    logic            s1_vld;
    logic            s1_last;
    logic [IDXW-1:0] s1_idx;
    logic [31:0]     s1_sum;
    logic            s1_cout;
    logic [32:0]     s1_exp;
    logic            match;

    // Vectors arriving after the last result has been registered are ignored.
    assign accept = vld && !clear && (state != DONE);
    assign match  = ({s1_cout, s1_sum} == s1_exp);

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_idx  <= '0;
            s1_sum  <= '0;
            s1_cout <= 1'b0;
            s1_exp  <= '0;
        end else if (clear) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_last <= last;
                s1_idx  <= idx;
                s1_sum  <= sum;
                s1_cout <= cout;
                s1_exp  <= {1'b0, a} + {1'b0, b} + {32'd0, cin};
            end
        end
    end

    // An X on the adder outputs makes match unknown, which takes the fail branch.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state          <= IDLE;
            chk_vld        <= 1'b0;
            chk_ok         <= 1'b0;
            pass_cnt       <= '0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_seen <= 1'b0;
            done           <= 1'b0;
        end else if (clear) begin
            state          <= IDLE;
            chk_vld        <= 1'b0;
            chk_ok         <= 1'b0;
            pass_cnt       <= '0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_seen <= 1'b0;
            done           <= 1'b0;
        end else begin
            chk_vld <= s1_vld;
            chk_ok  <= 1'b0;
            if (s1_vld) begin
                if (match) begin
                    chk_ok <= 1'b1;
                    if (pass_cnt != CNT_MAX)
                        pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (err_cnt != CNT_MAX)
                        err_cnt <= err_cnt + 1'b1;
                    if (!first_err_seen) begin
                        first_err_idx  <= s1_idx;
                        first_err_seen <= 1'b1;
                    end
                end
            end
            case (state)
                IDLE: if (accept) state <= RUN;
                RUN: begin
                    if (s1_vld && s1_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADD32_CHECK_DISPLAY_EN
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    logic        s1_cin;
    logic        done_d;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            s1_a   <= '0;
            s1_b   <= '0;
            s1_cin <= 1'b0;
            done_d <= 1'b0;
        end else begin
            done_d <= done;
            if (accept) begin
                s1_a   <= a;
                s1_b   <= b;
                s1_cin <= cin;
            end
            if (!clear && s1_vld && !match)
                $display("add32_check: mismatch idx=%0d a=%h b=%h cin=%b got=%h exp=%h",
                         s1_idx, s1_a, s1_b, s1_cin, {s1_cout, s1_sum}, s1_exp);
            if (done && !done_d)
                $display("add32_check: done pass=%0d err=%0d", pass_cnt, err_cnt);
        end
    end
`endif

endmodule
